apb_to_regif: RTL
=================

Name: apb_to_regif

Overview:
- APB4 subordinate that converts APB transfers into a PeakRDL-style register-block CPU interface (req/ack, stall, separate read/write acks).
- Sits directly downstream of the OBI-to-APB adapter and directly upstream of the generated register block.
- Accepts one outstanding transfer at a time.
- Registers every response before returning it on pready.

Parameters:
- AddrWidth, 32, width of paddr and cpuif_addr.
- DataWidth, 32, width of pwdata, prdata and cpuif data; must be a multiple of 8.
- TimeoutCycles, 256, number of WAIT cycles without an ack before the transfer is aborted (used only with the optional feature); must be >= 1.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- psel_i  in  1  APB select
- penable_i  in  1  APB enable (access phase)
- pwrite_i  in  1  APB write
- paddr_i  in  AddrWidth  APB address
- pwdata_i  in  DataWidth  APB write data
- pstrb_i  in  DataWidth/8  APB byte strobes
- pprot_i  in  3  APB protection; ignored
- pready_o  out  1  APB ready
- prdata_o  out  DataWidth  APB read data
- pslverr_o  out  1  APB error
- cpuif_req_o  out  1  register-block request
- cpuif_req_is_wr_o  out  1  request is a write
- cpuif_addr_o  out  AddrWidth  request address
- cpuif_wr_data_o  out  DataWidth  write data
- cpuif_wr_biten_o  out  DataWidth  per-bit write enable
- cpuif_req_stall_wr_i  in  1  block cannot accept a write
- cpuif_req_stall_rd_i  in  1  block cannot accept a read
- cpuif_rd_ack_i  in  1  read complete
- cpuif_rd_err_i  in  1  read error, valid with rd_ack
- cpuif_rd_data_i  in  DataWidth  read data, valid with rd_ack
- cpuif_wr_ack_i  in  1  write complete
- cpuif_wr_err_i  in  1  write error, valid with wr_ack
- timeout_o  out  1  one-cycle pulse on a timeout abort (only with the optional feature; tied 0 otherwise)

Behaviour:
- Clocking and reset: single clock clk_i. rst_i is synchronous and active-high.
- Reset values:
  - FSM returns to IDLE.
  - pready_o=0, pslverr_o=0, prdata_o=0, cpuif_req_o=0, timeout_o=0.
  - Response registers and timeout counter cleared.
- Reset mid-transfer: the transfer is abandoned. No pready is issued. An ack arriving in the cycle after reset is ignored.

FSM states: IDLE, WAIT, RESP.
- IDLE
  - cpuif_req_o = psel_i & penable_i & ~stall, where stall = pwrite_i ? stall_wr : stall_rd.
  - Request fields are driven combinationally from the APB inputs:
    - req_is_wr = pwrite_i
    - addr = paddr_i
    - wr_data = pwdata_i when writing, else 0
    - wr_biten = each pstrb bit replicated 8 times when writing, else 0
  - Stall asserted: remain in IDLE and re-evaluate every cycle. APB holds its inputs stable during this time.
  - Request issued with a matching same-cycle ack: capture the response and go to RESP.
  - Request issued without an ack: latch the transfer direction and go to WAIT.
  - psel_i & ~penable_i (setup phase): no action.
- WAIT
  - cpuif_req_o = 0.
  - Only an ack matching the latched direction counts: rd_ack for reads, wr_ack for writes. A non-matching ack is ignored.
  - On a matching ack, capture data and err (data forced to 0 for writes), then go to RESP.
  - A psel_i drop during WAIT is a protocol violation. It is ignored and the transfer completes normally.
- RESP
  - pready_o=1 for exactly one cycle, with the registered prdata_o/pslverr_o; then return to IDLE.
  - prdata_o and pslverr_o are 0 in every state other than RESP.
- Latency:
  - Same-cycle ack in the first access cycle gives pready in the next cycle, i.e. a 2-cycle access phase.
  - In general, pready comes 1 cycle after the accepting ack.
  - No combinational path from cpuif ack to pready.
- Back-to-back: the IDLE cycle after RESP is the next APB setup cycle. The earliest next request is 2 cycles after RESP.
- Acks received in IDLE or RESP are dropped.

Optional Feature:
- Macro: APB_TO_REGIF_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TimeoutCycles with no matching ack: go to RESP with pslverr_o=1, prdata_o=0, and pulse timeout_o for that one cycle.
  - An ack arriving in the same cycle the count is reached takes priority: normal response, no timeout.
  - Late acks after the abort are dropped per the IDLE rule.
  - Counter width is $clog2(TimeoutCycles+1).
- Undefined: no counter; WAIT holds indefinitely; timeout_o tied 0.

Test Plan:
- Read with same-cycle ack: paddr=0x10, rd_ack with rd_data=0xDEADBEEF in first access cycle -> req pulses 1 cycle; pready next cycle with prdata=0xDEADBEEF, pslverr=0.
- Write with strobes: pwdata=0x11223344, pstrb=4'b0101, wr_ack 3 cycles later -> wr_biten=0x00FF00FF, wr_data=0x11223344; pready 1 cycle after ack; prdata=0.
- Stall: stall_rd=1 for 4 cycles during a read -> cpuif_req_o=0 for those cycles, then one req cycle when stall drops; no pready until ack+1.
- Error and ack mismatch: during a write, rd_ack=1 then wr_ack=1 with wr_err=1 -> rd_ack ignored; pready with pslverr=1.
- Timeout (macro on, TimeoutCycles=8): read never acked -> pready and timeout_o after 8 WAIT cycles, pslverr=1, prdata=0; a later rd_ack is ignored and the next transfer completes normally.
- Reset mid-WAIT: rst_i=1 for 1 cycle during WAIT -> all outputs 0, FSM in IDLE; a subsequent stray ack produces no pready.

Source files
------------

// File: rtl/apb_to_regif.sv
// APB4 subordinate bridging one transfer at a time onto a PeakRDL-style register-block CPU interface.
// Optional WAIT-state timeout abort is enabled by defining APB_TO_REGIF_TIMEOUT_EN.
module apb_to_regif #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [DataWidth-1:0]   pwdata_i,
  input  logic [DataWidth/8-1:0] pstrb_i,
  input  logic [2:0]             pprot_i,
  output logic                   pready_o,
  output logic [DataWidth-1:0]   prdata_o,
  output logic                   pslverr_o,
  output logic                   cpuif_req_o,
  output logic                   cpuif_req_is_wr_o,
  output logic [AddrWidth-1:0]   cpuif_addr_o,
  output logic [DataWidth-1:0]   cpuif_wr_data_o,
  output logic [DataWidth-1:0]   cpuif_wr_biten_o,
  input  logic                   cpuif_req_stall_wr_i,
  input  logic                   cpuif_req_stall_rd_i,
  input  logic                   cpuif_rd_ack_i,
  input  logic                   cpuif_rd_err_i,
  input  logic [DataWidth-1:0]   cpuif_rd_data_i,
  input  logic                   cpuif_wr_ack_i,
  input  logic                   cpuif_wr_err_i,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic                 isWr_q, isWr_d;
  logic [DataWidth-1:0] respData_q, respData_d;
  logic                 respErr_q, respErr_d;
  logic                 stall, dirWr, ackHit;
  logic                 unused;

  assign unused = ^pprot_i ^ (TimeoutCycles < 1);

  always_comb begin
    stall             = pwrite_i ? cpuif_req_stall_wr_i : cpuif_req_stall_rd_i;
    cpuif_req_o       = (state_q == IDLE) & psel_i & penable_i & ~stall;
    cpuif_req_is_wr_o = pwrite_i;
    cpuif_addr_o      = paddr_i;
    cpuif_wr_data_o   = pwrite_i ? pwdata_i : '0;
    cpuif_wr_biten_o  = '0;
    for (int i = 0; i < DataWidth / 8; i++) begin
      cpuif_wr_biten_o[8*i +: 8] = {8{pwrite_i & pstrb_i[i]}};
    end
  end

`ifdef APB_TO_REGIF_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            toFlag_q, toFlag_d;
`endif

  // In IDLE the live APB direction selects the ack; in WAIT only the latched direction counts.
  always_comb begin
    state_d    = state_q;
    isWr_d     = isWr_q;
    respData_d = respData_q;
    respErr_d  = respErr_q;
`ifdef APB_TO_REGIF_TIMEOUT_EN
    cnt_d      = cnt_q;
    toFlag_d   = 1'b0;
`endif
    dirWr  = (state_q == IDLE) ? pwrite_i : isWr_q;
    ackHit = dirWr ? cpuif_wr_ack_i : cpuif_rd_ack_i;
    unique case (state_q)
      IDLE: begin
        if (cpuif_req_o) begin
          isWr_d = pwrite_i;
          if (ackHit) begin
            respData_d = dirWr ? '0 : cpuif_rd_data_i;
            respErr_d  = dirWr ? cpuif_wr_err_i : cpuif_rd_err_i;
            state_d    = RESP;
          end else begin
            state_d = WAIT;
`ifdef APB_TO_REGIF_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      WAIT: begin
        if (ackHit) begin
          respData_d = dirWr ? '0 : cpuif_rd_data_i;
          respErr_d  = dirWr ? cpuif_wr_err_i : cpuif_rd_err_i;
          state_d    = RESP;
        end
`ifdef APB_TO_REGIF_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(TimeoutCycles)) begin
            respData_d = '0;
            respErr_d  = 1'b1;
            toFlag_d   = 1'b1;
            state_d    = RESP;
          end
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      isWr_q     <= 1'b0;
      respData_q <= '0;
      respErr_q  <= 1'b0;
`ifdef APB_TO_REGIF_TIMEOUT_EN
      cnt_q      <= '0;
      toFlag_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      isWr_q     <= isWr_d;
      respData_q <= respData_d;
      respErr_q  <= respErr_d;
`ifdef APB_TO_REGIF_TIMEOUT_EN
      cnt_q      <= cnt_d;
      toFlag_q   <= toFlag_d;
`endif
    end
  end

  // Response is only visible during the single RESP cycle; zero elsewhere.
  assign pready_o  = (state_q == RESP);
  assign prdata_o  = pready_o ? respData_q : '0;
  assign pslverr_o = pready_o & respErr_q;
`ifdef APB_TO_REGIF_TIMEOUT_EN
  assign timeout_o = pready_o & toFlag_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
